multicycle_ctrl: RTL and testbench

//  Control unit for the multicycle RV32I datapath (cpu). It decodes Instr fields and sequences

---
 rtl/multicycle_ctrl_if.sv | 39 +++
 rtl/multicycle_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [2:0] ALUControl;
  logic       Retire;
  logic       Illegal;
  logic [3:0] state_o;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite,
    output IRWrite, ResultSrc, ALUSrcA,
    output ALUSrcB, ImmSrc, RegWrite,
    output ALUControl, Retire, Illegal,
    output state_o
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite,
    input  IRWrite, ResultSrc, ALUSrcA,
    input  ALUSrcB, ImmSrc, RegWrite,
    input  ALUControl, Retire, Illegal,
    input  state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-style sequencer for the multicycle RV32I datapath.
// Only PCWrite, ALUControl and ImmSrc look at live inputs.
module multicycle_ctrl #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input logic clk,
  input logic rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam state_t ILL_NXT =
    HALT_ON_ILLEGAL ? HALT : FETCH;

  state_t     state;
  state_t     nxt;
  logic       ill_q;
  logic       ill_set;
  logic       f3_ok;
  logic       pcupdate;
  logic       branch;
  logic [1:0] aluop;
  logic       irw;
  logic       rw;
  logic       mw;
  logic       ret;
  logic       adr;
  logic [1:0] rsrc;
  logic [1:0] srca;
  logic [1:0] srcb;
  logic [2:0] aluctl;
  logic [1:0] imm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ill_q <= 1'b0;
    else if (ill_set) ill_q <= 1'b1;
  end

  assign f3_ok = (bus.funct3 == 3'b000) ||
                 (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b110) ||
                 (bus.funct3 == 3'b111);

  always_comb begin
    nxt      = state;
    ill_set  = 1'b0;
    pcupdate = 1'b0;
    branch   = 1'b0;
    aluop    = 2'b00;
    irw      = 1'b0;
    rw       = 1'b0;
    mw       = 1'b0;
    ret      = 1'b0;
    adr      = 1'b0;
    rsrc     = 2'b00;
    srca     = 2'b00;
    srcb     = 2'b00;
    unique case (state)
      FETCH: begin
        irw      = 1'b1;
        srcb     = 2'b10;
        rsrc     = 2'b10;
        pcupdate = 1'b1;
        nxt      = DECODE;
      end
      DECODE: begin
        srca = 2'b01;
        srcb = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECR;
          OP_I:         nxt = EXECI;
          OP_BEQ:       nxt = BEQ;
          OP_JAL:       nxt = JAL;
          default: begin
            ill_set = 1'b1;
            nxt     = ILL_NXT;
          end
        endcase
      end
      MEMADR: begin
        srca = 2'b10;
        srcb = 2'b01;
        nxt  = (bus.op == OP_LW) ? MEMREAD
                                 : MEMWRITE;
      end
      MEMREAD: begin
        adr = 1'b1;
        nxt = MEMWB;
      end
      MEMWB: begin
        rsrc = 2'b01;
        rw   = 1'b1;
        ret  = 1'b1;
        nxt  = FETCH;
      end
      MEMWRITE: begin
        adr = 1'b1;
        mw  = 1'b1;
        ret = 1'b1;
        nxt = FETCH;
      end
      EXECR, EXECI: begin
        srca  = 2'b10;
        srcb  = (state == EXECI) ? 2'b01
                                 : 2'b00;
        aluop = 2'b10;
        if (f3_ok) begin
          nxt = ALUWB;
        end else begin
          ill_set = 1'b1;
          nxt     = ILL_NXT;
        end
      end
      ALUWB: begin
        rw  = 1'b1;
        ret = 1'b1;
        nxt = FETCH;
      end
      BEQ: begin
        srca   = 2'b10;
        aluop  = 2'b01;
        branch = 1'b1;
        ret    = 1'b1;
        nxt    = FETCH;
      end
      JAL: begin
        srca     = 2'b01;
        srcb     = 2'b10;
        pcupdate = 1'b1;
        nxt      = ALUWB;
      end
      HALT: nxt = HALT;
      default: nxt = FETCH;
    endcase
  end

  // sub only for R-type: I-type bit 30 is immediate data
  always_comb begin
    aluctl = 3'b000;
    unique case (1'b1)
      aluop == 2'b01:
        aluctl = 3'b001;
      aluop == 2'b10 && bus.funct3 == 3'b000:
        aluctl = (bus.op[5] && bus.funct7b5)
                 ? 3'b001 : 3'b000;
      aluop == 2'b10 && bus.funct3 == 3'b010:
        aluctl = 3'b101;
      aluop == 2'b10 && bus.funct3 == 3'b110:
        aluctl = 3'b011;
      aluop == 2'b10 && bus.funct3 == 3'b111:
        aluctl = 3'b010;
      default:
        aluctl = 3'b000;
    endcase
  end

  always_comb begin
    imm = 2'b00;
    case (bus.op)
      OP_SW:   imm = 2'b01;
      OP_BEQ:  imm = 2'b10;
      OP_JAL:  imm = 2'b11;
      default: imm = 2'b00;
    endcase
  end

  assign bus.PCWrite    = ~rst &
                          (pcupdate | (branch & bus.Zero));
  assign bus.IRWrite    = ~rst & irw;
  assign bus.RegWrite   = ~rst & rw;
  assign bus.MemWrite   = ~rst & mw;
  assign bus.Retire     = ~rst & ret;
  assign bus.AdrSrc     = adr;
  assign bus.ResultSrc  = rsrc;
  assign bus.ALUSrcA    = srca;
  assign bus.ALUSrcB    = srcb;
  assign bus.ImmSrc     = imm;
  assign bus.ALUControl = aluctl;
  assign bus.Illegal    = ill_q;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: one HALT-mode and one NOP-mode
// instance share inputs; per-cycle expected outputs are queued and checked.
module tb_multicycle_ctrl;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic       rw;
    logic [2:0] alu;
    logic       ret;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7;
  logic       zero;

  int total = 0;
  int bad   = 0;

  exp_t  q0[$];
  exp_t  q1[$];
  string n0[$];
  string n1[$];

  multicycle_ctrl_if b0();
  multicycle_ctrl_if b1();

  assign b0.op = op;
  assign b0.funct3 = f3;
  assign b0.funct7b5 = f7;
  assign b0.Zero = zero;
  assign b1.op = op;
  assign b1.funct3 = f3;
  assign b1.funct7b5 = f7;
  assign b1.Zero = zero;

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1)) u_halt (
    .clk(clk), .rst(rst), .bus(b0)
  );

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0)) u_nop (
    .clk(clk), .rst(rst), .bus(b1)
  );

  always #5 clk = ~clk;

  // Expected outputs per state, straight from the state output table.
  function automatic exp_t mk(
    input logic [3:0] s, input logic [1:0] imm,
    input logic [2:0] ea, input logic z,
    input logic il, input logic r);
    exp_t e;
    e = '0;
    e.st = s;
    e.imm = imm;
    e.ill = il;
    case (s)
      S_FETCH: begin
        e.irw = 1; e.sb = 2; e.rs = 2; e.pcw = 1;
      end
      S_DECODE: begin e.sa = 1; e.sb = 1; end
      S_MEMADR: begin e.sa = 2; e.sb = 1; end
      S_MEMREAD: e.adr = 1;
      S_MEMWB: begin
        e.rs = 1; e.rw = 1; e.ret = 1;
      end
      S_MEMWRITE: begin
        e.adr = 1; e.mw = 1; e.ret = 1;
      end
      S_EXECR: begin e.sa = 2; e.alu = ea; end
      S_EXECI: begin
        e.sa = 2; e.sb = 1; e.alu = ea;
      end
      S_ALUWB: begin e.rw = 1; e.ret = 1; end
      S_BEQ: begin
        e.sa = 2; e.alu = 3'b001;
        e.pcw = z; e.ret = 1;
      end
      S_JAL: begin
        e.sa = 1; e.sb = 2; e.pcw = 1;
      end
      default: ;
    endcase
    if (r) begin
      e.pcw = 0; e.irw = 0; e.rw = 0;
      e.mw = 0; e.ret = 0;
    end
    return e;
  endfunction

  function automatic exp_t got(input int w);
    if (w == 0)
      return {b0.state_o, b0.PCWrite, b0.AdrSrc,
              b0.MemWrite, b0.IRWrite, b0.ResultSrc,
              b0.ALUSrcA, b0.ALUSrcB, b0.ImmSrc,
              b0.RegWrite, b0.ALUControl, b0.Retire,
              b0.Illegal};
    return {b1.state_o, b1.PCWrite, b1.AdrSrc,
            b1.MemWrite, b1.IRWrite, b1.ResultSrc,
            b1.ALUSrcA, b1.ALUSrcB, b1.ImmSrc,
            b1.RegWrite, b1.ALUControl, b1.Retire,
            b1.Illegal};
  endfunction

  task automatic push(
    input int w, input string nm, input logic [3:0] s,
    input logic [1:0] imm, input logic [2:0] ea,
    input logic il, input logic r);
    exp_t e;
    e = mk(s, imm, ea, zero, il, r);
    if (w != 1) begin q0.push_back(e); n0.push_back(nm); end
    if (w != 0) begin q1.push_back(e); n1.push_back(nm); end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setin(
    input logic [6:0] o, input logic [2:0] fn3,
    input logic b5, input logic z);
    op = o; f3 = fn3; f7 = b5; zero = z;
  endtask

  // Queue n states (nibbles of seq, low first) for queue(s) w.
  task automatic pushseq(
    input int w, input string nm, input logic [19:0] seq,
    input int n, input logic [1:0] imm,
    input logic [2:0] ea, input logic il);
    for (int i = 0; i < n; i++)
      push(w, nm, seq[4*i +: 4], imm, ea, il, 1'b0);
  endtask

  task automatic run(
    input string nm, input logic [6:0] o,
    input logic [2:0] fn3, input logic b5,
    input logic z, input logic [1:0] imm,
    input logic [2:0] ea, input logic [19:0] seq,
    input int n);
    setin(o, fn3, b5, z);
    pushseq(2, nm, seq, n, imm, ea, 1'b0);
    tick(n);
  endtask

  task automatic do_reset(input int n, input logic [1:0] imm);
    rst = 1'b1;
    for (int i = 0; i < n; i++)
      push(2, "reset", S_FETCH, imm, 3'b000, 1'b0, 1'b1);
    tick(n);
    rst = 1'b0;
  endtask

  localparam logic [19:0] SQ_I =
    {S_FETCH, S_ALUWB, S_EXECI, S_DECODE, S_FETCH};
  localparam logic [19:0] SQ_R =
    {S_FETCH, S_ALUWB, S_EXECR, S_DECODE, S_FETCH};
  localparam logic [19:0] SQ_LW =
    {S_MEMWB, S_MEMREAD, S_MEMADR, S_DECODE, S_FETCH};
  localparam logic [19:0] SQ_SW =
    {S_FETCH, S_MEMWRITE, S_MEMADR, S_DECODE, S_FETCH};
  localparam logic [19:0] SQ_BEQ =
    {S_FETCH, S_FETCH, S_BEQ, S_DECODE, S_FETCH};
  localparam logic [19:0] SQ_JAL =
    {S_FETCH, S_ALUWB, S_JAL, S_DECODE, S_FETCH};
  localparam logic [19:0] SQ_ILL =
    {S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_FETCH};
  localparam logic [19:0] SQ_ILR =
    {S_FETCH, S_FETCH, S_EXECR, S_DECODE, S_FETCH};

  always @(negedge clk) begin
    exp_t  e;
    exp_t  g;
    string nm;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      nm = n0.pop_front();
      g = got(0);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL halt/%s st=%0d got=%h want=%h",
                 nm, e.st, g, e);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      nm = n1.pop_front();
      g = got(1);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL nop/%s st=%0d got=%h want=%h",
                 nm, e.st, g, e);
      end
    end
  end

  initial begin
    rst = 1'b1;
    setin(7'h00, 3'b000, 1'b0, 1'b0);
    tick(1);
    do_reset(2, 2'b00);

    run("addi", 7'b0010011, 3'b000, 1'b0, 1'b0,
        2'b00, 3'b000, SQ_I, 4);
    run("addi_neg", 7'b0010011, 3'b000, 1'b1, 1'b0,
        2'b00, 3'b000, SQ_I, 4);
    run("slti", 7'b0010011, 3'b010, 1'b0, 1'b0,
        2'b00, 3'b101, SQ_I, 4);
    run("andi", 7'b0010011, 3'b111, 1'b0, 1'b0,
        2'b00, 3'b010, SQ_I, 4);
    run("ori", 7'b0010011, 3'b110, 1'b0, 1'b0,
        2'b00, 3'b011, SQ_I, 4);
    run("sub", 7'b0110011, 3'b000, 1'b1, 1'b0,
        2'b00, 3'b001, SQ_R, 4);
    run("add", 7'b0110011, 3'b000, 1'b0, 1'b1,
        2'b00, 3'b000, SQ_R, 4);
    run("slt", 7'b0110011, 3'b010, 1'b0, 1'b0,
        2'b00, 3'b101, SQ_R, 4);
    run("and", 7'b0110011, 3'b111, 1'b0, 1'b0,
        2'b00, 3'b010, SQ_R, 4);
    run("or", 7'b0110011, 3'b110, 1'b0, 1'b0,
        2'b00, 3'b011, SQ_R, 4);
    run("lw", 7'b0000011, 3'b010, 1'b0, 1'b1,
        2'b00, 3'b000, SQ_LW, 5);
    run("sw", 7'b0100011, 3'b010, 1'b0, 1'b1,
        2'b01, 3'b000, SQ_SW, 4);
    run("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1,
        2'b10, 3'b000, SQ_BEQ, 3);
    run("beq_nt", 7'b1100011, 3'b000, 1'b0, 1'b0,
        2'b10, 3'b000, SQ_BEQ, 3);
    run("jal", 7'b1101111, 3'b000, 1'b0, 1'b0,
        2'b11, 3'b000, SQ_JAL, 4);

    // lw abandoned by async reset in MEMREAD
    run("lw_abort", 7'b0000011, 3'b010, 1'b0, 1'b0,
        2'b00, 3'b000, SQ_LW, 3);
    do_reset(2, 2'b00);
    run("addi_rst", 7'b0010011, 3'b000, 1'b0, 1'b0,
        2'b00, 3'b000, SQ_I, 4);

    // illegal opcode: HALT instance parks, NOP one keeps going
    run("ill_op", 7'h7F, 3'b000, 1'b0, 1'b0,
        2'b00, 3'b000, SQ_ILL, 2);
    setin(7'b0010011, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      push(0, "halt", S_HALT, 2'b00, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      pushseq(1, "addi_sticky", SQ_I, 4, 2'b00,
              3'b000, 1'b1);
    tick(20);

    do_reset(2, 2'b00);

    // illegal funct3 caught in EXECR
    run("ill_f3", 7'b0110011, 3'b001, 1'b0, 1'b0,
        2'b00, 3'b000, SQ_ILR, 3);
    for (int i = 0; i < 3; i++)
      push(0, "halt_f3", S_HALT, 2'b00, 3'b000,
           1'b1, 1'b0);
    pushseq(1, "nop_f3", SQ_ILR, 3, 2'b00, 3'b000, 1'b1);
    tick(3);
    tick(1);

    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0",
               q0.size() + q1.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
